// File: rtl/pr_uart_tx_pkg.sv
// rtl/pr_uart_tx_pkg.sv - shared register map, bit positions and FSM encoding for pr_uart_tx
//   Purpose: constants and types shared by the UART transmitter, its FIFO and the bus interface.
//   Ports:   none (package).
package pr_uart_tx_pkg;

  // Register offsets decoded from Addr[3:2]
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  // STATUS bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_IRQ   = 3;
  localparam int ST_OVF   = 4;

  // CTRL bit positions
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Frame FSM encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // A programmed divisor of 0 runs at one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/pr_uart_tx_if.sv
// rtl/pr_uart_tx_if.sv - Pr-bus register access interface between bridge and UART
//   Purpose: groups the bridge-side register bus.
//   Signals: Addr[31:2] word address, WE write strobe, Din write data, Dout read data.
//   Modports: master (bridge), slave (device).
interface pr_uart_tx_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/pr_uart_fifo.sv
// rtl/pr_uart_fifo.sv - synchronous byte FIFO for the UART transmitter
//   Purpose: DEPTH-entry byte queue with first-word-fall-through read data.
//   Ports:   clk, reset (async, active-high), push_i/wdata_i write side,
//            pop_i/rdata_o read side, full_o, empty_o status.
module pr_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/pr_uart_tx.sv
// rtl/pr_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and drain interrupt
//   Purpose: register file, bit divider, shift register and frame FSM.
//   Ports:   clk, reset (async, active-high), bus (register slave: Addr/WE/Din/Dout),
//            IRQ level interrupt, txd serial output (idles high).
module pr_uart_tx
  import pr_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic         clk,
  input  logic         reset,
  pr_uart_tx_if.slave  bus,
  output logic         IRQ,
  output logic         txd
);

  logic        tx_en_q, irq_en_q, ovf_q, txd_q;
  logic [15:0] divisor_q, div_lat_q, cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  state_t      state_q;

  logic [1:0]  reg_sel;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [15:0] div_eff;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign reg_sel   = bus.Addr[3:2];
  assign fifo_push = bus.WE && (reg_sel == REG_DATA);
  assign div_eff   = eff_div(divisor_q);
  // A frame starts from IDLE, or directly out of the last STOP cycle with no gap.
  assign fifo_pop  = tx_en_q && !fifo_empty &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && (cnt_q == 16'd0)));
  assign unused_ok = &{1'b0, bus.Addr[31:4], bus.Din[31:16]};

  pr_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (bus.Din[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      divisor_q <= DIV_RESET;
      ovf_q     <= 1'b0;
    end else begin
      if (bus.WE) begin
        case (reg_sel)
          REG_STATUS:  ovf_q <= 1'b0;
          REG_CTRL: begin
            tx_en_q  <= bus.Din[CTRL_TX_EN];
            irq_en_q <= bus.Din[CTRL_IRQ_EN];
          end
          REG_DIVISOR: divisor_q <= bus.Din[15:0];
          default: ;
        endcase
      end
      if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  // cnt_q counts D-1 down to 0; each phase advances on the edge where it reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      div_lat_q <= 16'd1;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
    end else if (fifo_pop) begin
      // Divisor is latched per frame so mid-frame writes only affect the next one.
      state_q   <= S_START;
      shift_q   <= fifo_rdata;
      div_lat_q <= div_eff;
      cnt_q     <= div_eff - 16'd1;
      txd_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: txd_q <= 1'b1;
        S_START: begin
          if (cnt_q == 16'd0) begin
            state_q   <= S_DATA;
            bit_idx_q <= 3'd0;
            cnt_q     <= div_lat_q - 16'd1;
            txd_q     <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= div_lat_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 16'd0) state_q <= S_IDLE;
          else                cnt_q   <= cnt_q - 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign txd = txd_q;
  assign IRQ = irq_en_q && fifo_empty && (state_q == S_IDLE);

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_STATUS: begin
        rd_data[ST_EMPTY] = fifo_empty;
        rd_data[ST_FULL]  = fifo_full;
        rd_data[ST_BUSY]  = (state_q != S_IDLE);
        rd_data[ST_IRQ]   = IRQ;
        rd_data[ST_OVF]   = ovf_q;
      end
      REG_CTRL: begin
        rd_data[CTRL_TX_EN]  = tx_en_q;
        rd_data[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_DIVISOR: rd_data[15:0] = divisor_q;
      default: ;
    endcase
  end

  assign bus.Dout = rd_data;

endmodule

// File: doc/pr_uart_tx.md
# pr_uart_tx

Memory-mapped UART transmitter that hangs off the bridge's device side as a Pr-bus responder, next to the two timers. The CPU writes bytes through the bridge. The block buffers them in a small FIFO, serialises them onto `txd` as 8N1 frames, and raises a level interrupt on a HWInt line once the queue has drained. Register access follows the timer convention: synchronous write on `WE`, combinational read on `Dout`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of two, at least 2.
- `DIV_RESET`, 16'd16: reset value of DIVISOR, in clock cycles per bit.

Ports:
- `clk` in 1: single system clock; every flop is clocked on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `Addr` in 30 (`[31:2]`): word address from the bridge; only `Addr[3:2]` is decoded.
- `WE` in 1: write strobe; already qualified by the bridge address decode.
- `Din` in 32: write data.
- `Dout` out 32: combinational read data for `Addr[3:2]`.
- `IRQ` out 1: level interrupt.
- `txd` out 1: serial output; idles high.

## Operation
Register map, selected by `Addr[3:2]`:
- 0, DATA: a write pushes `Din[7:0]` into the FIFO. Reads return 0.
- 1, STATUS: read-only bits:
  - bit0 = fifo_empty
  - bit1 = fifo_full
  - bit2 = busy (FSM not in IDLE)
  - bit3 = IRQ
  - bit4 = overflow (sticky)
  - A write of any value clears overflow.
- 2, CTRL: read/write.
  - bit0 = tx_en, reset 0.
  - bit1 = irq_en, reset 0.
  - Other bits read as 0.
- 3, DIVISOR: read/write, bits [15:0].
  - A value of 0 behaves as 1.
  - The value is latched at each frame start, so a write mid-frame affects only the next frame.

Frame FSM states: IDLE, START, DATA, STOP.
- IDLE -> START when tx_en is set and the FIFO is non-empty. The FIFO is popped and the byte loaded into the shift register on that same edge.
- START: `txd`=0 for D cycles, then -> DATA with bit index 0.
- DATA: `txd` = shift[0] for D cycles per bit, LSB first. After bit 7 -> STOP.
- STOP: `txd`=1 for D cycles, then:
  - -> START (pop the next byte) if tx_en is set and the FIFO is non-empty; there is no idle gap between frames.
  - otherwise -> IDLE.
- Clearing tx_en mid-frame does not abort the frame: the current frame completes and no new frame starts.

Interrupt and boundary behaviour:
- `IRQ` = irq_en & fifo_empty & (state==IDLE).
- Push while full: the byte is dropped, overflow is set, and the FIFO is unchanged.
- Push and pop in the same cycle when full: both happen. The pop frees a slot, so the push is accepted and overflow is not set.
- Push while empty and idle: the byte is written into the FIFO, then popped on the next edge.
- FIFO pointers wrap modulo `FIFO_DEPTH`, with one extra bit to tell full from empty.

## Timing
- Reset values: `txd`=1, `IRQ`=0, state IDLE, FIFO empty, CTRL=0, DIVISOR=`DIV_RESET`, overflow=0. `Dout` reflects the reset register values immediately.
- Reset asserted mid-frame forces `txd` high asynchronously.
- A write to DATA at edge t with the FSM idle and enabled gives:
  - START at edge t+1, with `txd` falling after that edge.
  - Frame length is exactly 10·D cycles.
  - `busy` is visible from t+1.
- A bit counter counts D−1 down to 0; the bit transition happens on the edge where it reads 0.
- STATUS reads are combinational and reflect register state after the most recent edge.

## Structure
- Shared package holds:
  - register offset constants DATA/STATUS/CTRL/DIVISOR = 0..3;
  - STATUS and CTRL bit positions;
  - FSM state encoding (2-bit localparams).
- One sub-module, `pr_uart_fifo`: synchronous byte FIFO with push, pop, full, empty and DEPTH parameter.
- The top level holds the register file, divider counter, shift register and FSM.

## Test plan
- Reset: after reset release, with no writes, `txd`=1, `IRQ`=0, and STATUS reads 0x1 for 20 cycles.
- Single byte: DIVISOR=4, CTRL=1, DATA=0xA5.
  - `txd` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1, 4 cycles each, then 1 for 4 cycles.
  - `busy` falls exactly 40 cycles after START.
- Back-to-back and IRQ: CTRL=3, DIVISOR=2, write 0x01, 0x02, 0x03 in consecutive cycles.
  - The three frames are contiguous, 60 cycles total.
  - `IRQ` stays 0 throughout and rises the cycle after the last STOP ends.
- Overflow: CTRL=0 and DEPTH=4; write 5 bytes.
  - STATUS = 0x12 (full + overflow).
  - Writing STATUS clears it to 0x2.
  - Setting CTRL=1 then transmits only the first 4 bytes.
- Divisor edge cases:
  - DIVISOR=0 gives 1 cycle per bit, a 10-cycle frame.
  - Writing DIVISOR=8 mid-frame leaves the current frame at the old rate; the next frame runs at 8.
- Reset mid-frame: assert `reset` during DATA bit 3.
  - `txd`=1 immediately, FIFO is empty.
  - After release, CTRL reads 0 and there is no further output.
